// File: rtl/cacheline_adaptor_if.sv
// Line-side (pmem) and burst-side signals of the cache line adaptor.
// The adaptor takes the slave view; the L2 and the memory model together take the master view.
interface cacheline_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64
);
  logic                   pmem_read;
  logic                   pmem_write;
  logic [31:0]            pmem_address;
  logic [LINE_WIDTH-1:0]  pmem_wdata;
  logic [LINE_WIDTH-1:0]  pmem_rdata;
  logic                   pmem_resp;
  logic                   burst_read;
  logic                   burst_write;
  logic [31:0]            burst_address;
  logic [BURST_WIDTH-1:0] burst_wdata;
  logic [BURST_WIDTH-1:0] burst_rdata;
  logic                   burst_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp,
    output burst_read, burst_write, burst_address, burst_wdata,
    input  burst_rdata, burst_resp
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    input  burst_read, burst_write, burst_address, burst_wdata,
    output burst_rdata, burst_resp
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts whole-line L2 read/write requests into BEATS-long bursts toward memory,
// answering each line with a one-cycle pmem_resp.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int BEATS       = LINE_WIDTH / BURST_WIDTH
) (
  input logic                clk,
  input logic                rst,
  cacheline_adaptor_if.slave bus
);
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [31:0]           r_addr;
  logic [LINE_WIDTH-1:0] r_line;
  logic                  w_addr_lo_unused;

  assign w_addr_lo_unused = ^bus.pmem_address[4:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a write wins over a simultaneous read
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.pmem_write) begin
          w_next = ST_WR;
        end else if (bus.pmem_read) begin
          w_next = ST_RD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RD, ST_WR: begin
        if (bus.burst_resp && (r_cnt == LAST)) begin
          w_next = ST_DONE;
        end else begin
          w_next = r_state;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, beat counter and line buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_addr <= 32'h0000_0000;
      r_line <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.pmem_write) begin
            r_addr <= {bus.pmem_address[31:5], 5'b00000};
            r_line <= bus.pmem_wdata;
            r_cnt  <= '0;
          end else if (bus.pmem_read) begin
            r_addr <= {bus.pmem_address[31:5], 5'b00000};
            r_cnt  <= '0;
          end
        end
        ST_RD: begin
          if (bus.burst_resp) begin
            r_line[r_cnt*BURST_WIDTH +: BURST_WIDTH] <= bus.burst_rdata;
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
          end
        end
        ST_WR: begin
          if (bus.burst_resp) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Outputs decoded from the registered state, counter and buffers
  always_comb begin
    bus.burst_read    = 1'b0;
    bus.burst_write   = 1'b0;
    bus.burst_address = 32'h0000_0000;
    bus.burst_wdata   = '0;
    bus.pmem_resp     = 1'b0;
    case (r_state)
      ST_RD: begin
        bus.burst_read    = 1'b1;
        bus.burst_address = r_addr;
      end
      ST_WR: begin
        bus.burst_write   = 1'b1;
        bus.burst_address = r_addr;
        bus.burst_wdata   = r_line[r_cnt*BURST_WIDTH +: BURST_WIDTH];
      end
      ST_DONE: bus.pmem_resp = 1'b1;
      default: bus.pmem_resp = 1'b0;
    endcase
  end

  assign bus.pmem_rdata = r_line;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: read, stalled write, arbitration,
// mid-burst reset, write-back/refill pair and stray burst_resp in IDLE.
module tb_cacheline_adaptor;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  logic [63:0]  rb [4];
  logic [63:0]  rb2 [4];
  logic [63:0]  wb [4];
  logic [255:0] wline;

  cacheline_adaptor_if #(.LINE_WIDTH(256), .BURST_WIDTH(64)) bus ();

  cacheline_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64), .BEATS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = 32'h0000_0000;
    bus.pmem_wdata   = '0;
    bus.burst_rdata  = 64'h0;
    bus.burst_resp   = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({bus.burst_read, bus.burst_write, bus.pmem_resp} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl got=%b want=000", {bus.burst_read, bus.burst_write, bus.pmem_resp});
    end
    n_checks++;
    if (bus.burst_address !== 32'h0 || bus.burst_wdata !== 64'h0 || bus.pmem_rdata !== 256'h0) begin
      n_err++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h want all zero", bus.burst_address, bus.burst_wdata, bus.pmem_rdata);
    end
  endtask

  // Full read of rb[] with continuous acknowledges; pmem_resp expected in cycle 5.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr, input string name);
    bus.pmem_read    = 1'b1;
    bus.pmem_address = addr;
    bus.burst_resp   = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      bus.burst_rdata = rb[c];
      n_checks++;
      if (bus.burst_read !== 1'b1 || bus.burst_write !== 1'b0 || bus.burst_address !== exp_addr || bus.pmem_resp !== 1'b0) begin
        n_err++; $display("FAIL %s_beat%0d rd=%b wr=%b addr=%h resp=%b want rd=1 wr=0 addr=%h resp=0",
                          name, c, bus.burst_read, bus.burst_write, bus.burst_address, bus.pmem_resp, exp_addr);
      end
      tick();
    end
    bus.burst_resp = 1'b0;
    n_checks++;
    if (bus.pmem_resp !== 1'b1 || bus.burst_read !== 1'b0) begin
      n_err++; $display("FAIL %s_resp resp=%b rd=%b want resp=1 rd=0", name, bus.pmem_resp, bus.burst_read);
    end
    n_checks++;
    if (bus.pmem_rdata !== {rb[3], rb[2], rb[1], rb[0]}) begin
      n_err++; $display("FAIL %s_rdata got=%h want=%h", name, bus.pmem_rdata, {rb[3], rb[2], rb[1], rb[0]});
    end
    bus.pmem_read = 1'b0;
    tick();
    n_checks++;
    if (bus.pmem_resp !== 1'b0) begin
      n_err++; $display("FAIL %s_resp_width resp=%b want=0", name, bus.pmem_resp);
    end
  endtask

  task automatic test_read();
    rb[0] = 64'h0000_0000_0000_0000;
    rb[1] = 64'h1111_1111_1111_1111;
    rb[2] = 64'h2222_2222_2222_2222;
    rb[3] = 64'h3333_3333_3333_3333;
    do_read(32'h0000_1234, 32'h0000_1220, "read");
  endtask

  task automatic test_write_stall();
    bus.pmem_write   = 1'b1;
    bus.pmem_address = 32'h0000_4455;
    bus.pmem_wdata   = wline;
    bus.burst_resp   = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        bus.burst_resp = (s == 2) ? 1'b1 : 1'b0;
        n_checks++;
        if (bus.burst_write !== 1'b1 || bus.burst_wdata !== wb[k] || bus.burst_address !== 32'h0000_4440 || bus.pmem_resp !== 1'b0) begin
          n_err++; $display("FAIL wr_beat%0d_s%0d wr=%b wdata=%h addr=%h resp=%b want wr=1 wdata=%h addr=00004440 resp=0",
                            k, s, bus.burst_write, bus.burst_wdata, bus.burst_address, bus.pmem_resp, wb[k]);
        end
        tick();
      end
    end
    bus.burst_resp = 1'b0;
    n_checks++;
    if (bus.pmem_resp !== 1'b1 || bus.burst_write !== 1'b0) begin
      n_err++; $display("FAIL wr_resp resp=%b wr=%b want resp=1 wr=0", bus.pmem_resp, bus.burst_write);
    end
    bus.pmem_write = 1'b0;
    tick();
    n_checks++;
    if (bus.pmem_resp !== 1'b0 || bus.burst_write !== 1'b0) begin
      n_err++; $display("FAIL wr_resp_width resp=%b wr=%b want 0 0", bus.pmem_resp, bus.burst_write);
    end
  endtask

  task automatic test_both_high();
    bus.pmem_read    = 1'b1;
    bus.pmem_write   = 1'b1;
    bus.pmem_address = 32'h0000_8000;
    bus.pmem_wdata   = wline;
    bus.burst_resp   = 1'b1;
    tick();
    n_checks++;
    if (bus.burst_write !== 1'b1 || bus.burst_read !== 1'b0) begin
      n_err++; $display("FAIL both_prio wr=%b rd=%b want wr=1 rd=0", bus.burst_write, bus.burst_read);
    end
    tick(); tick(); tick(); tick();
    bus.burst_resp = 1'b0;
    n_checks++;
    if (bus.pmem_resp !== 1'b1) begin
      n_err++; $display("FAIL both_resp resp=%b want=1", bus.pmem_resp);
    end
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'h0000_0040;
    bus.burst_resp   = 1'b1;
    bus.burst_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.burst_resp = 1'b0;
    n_checks++;
    if ({bus.burst_read, bus.burst_write, bus.pmem_resp} !== 3'b000 || bus.burst_address !== 32'h0 || bus.pmem_rdata !== 256'h0) begin
      n_err++; $display("FAIL rst_mid ctrl=%b addr=%h rdata=%h want all zero",
                        {bus.burst_read, bus.burst_write, bus.pmem_resp}, bus.burst_address, bus.pmem_rdata);
    end
    tick(); tick();
    n_checks++;
    if (bus.pmem_resp !== 1'b0 || bus.burst_read !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_quiet resp=%b rd=%b want 0 0", bus.pmem_resp, bus.burst_read);
    end
    rb[0] = 64'h0123_4567_89AB_CDEF;
    rb[1] = 64'hFEDC_BA98_7654_3210;
    rb[2] = 64'h5555_AAAA_5555_AAAA;
    rb[3] = 64'h0F0F_F0F0_0F0F_F0F0;
    do_read(32'h0000_005F, 32'h0000_0040, "rst_reread");
  endtask

  task automatic test_back_to_back();
    bus.pmem_write   = 1'b1;
    bus.pmem_address = 32'hABCD_0123;
    bus.pmem_wdata   = wline;
    bus.burst_resp   = 1'b1;
    tick();
    n_checks++;
    if (bus.burst_write !== 1'b1 || bus.burst_address !== 32'hABCD_0120) begin
      n_err++; $display("FAIL b2b_wb wr=%b addr=%h want wr=1 addr=abcd0120", bus.burst_write, bus.burst_address);
    end
    tick(); tick(); tick(); tick();
    bus.burst_resp = 1'b0;
    n_checks++;
    if (bus.pmem_resp !== 1'b1) begin
      n_err++; $display("FAIL b2b_wb_resp resp=%b want=1", bus.pmem_resp);
    end
    bus.pmem_write = 1'b0;
    tick();
    n_checks++;
    if (bus.pmem_resp !== 1'b0 || bus.burst_read !== 1'b0 || bus.burst_write !== 1'b0) begin
      n_err++; $display("FAIL b2b_gap resp=%b rd=%b wr=%b want 0 0 0", bus.pmem_resp, bus.burst_read, bus.burst_write);
    end
    for (int i = 0; i < 4; i++) rb[i] = rb2[i];
    do_read(32'h1357_9BDF, 32'h1357_9BC0, "b2b_refill");
  endtask

  task automatic test_idle_resp();
    bus.burst_resp  = 1'b1;
    bus.burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); tick(); tick();
    n_checks++;
    if ({bus.burst_read, bus.burst_write, bus.pmem_resp} !== 3'b000 || bus.burst_address !== 32'h0) begin
      n_err++; $display("FAIL idle_resp ctrl=%b addr=%h want 000 00000000",
                        {bus.burst_read, bus.burst_write, bus.pmem_resp}, bus.burst_address);
    end
    bus.burst_resp = 1'b0;
    rb[0] = 64'hA0A0_A0A0_0000_0001;
    rb[1] = 64'hB1B1_B1B1_0000_0002;
    rb[2] = 64'hC2C2_C2C2_0000_0003;
    rb[3] = 64'hD3D3_D3D3_0000_0004;
    do_read(32'h0000_0100, 32'h0000_0100, "post_idle");
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b0;
    wb[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    wb[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    wb[2] = 64'hCCCC_CCCC_CCCC_CCCC;
    wb[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    wline = {wb[3], wb[2], wb[1], wb[0]};
    rb2[0] = 64'h1000_0000_0000_000A;
    rb2[1] = 64'h2000_0000_0000_000B;
    rb2[2] = 64'h3000_0000_0000_000C;
    rb2[3] = 64'h4000_0000_0000_000D;
    test_reset();
    test_read();
    test_write_stall();
    test_both_high();
    test_reset_mid_burst();
    test_back_to_back();
    test_idle_resp();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
